// File: rtl/fmap_tap_gen.sv
// fmap_tap_gen: feature-map tap generator for the 2D convolution engine.
//
// Turns a raster-order pixel stream into KERNEL_SIZE-row column vectors. A line
// buffer of KERNEL_SIZE-1 row memories holds the previous rows; each accepted
// pixel emits the column {newest .. oldest} and shifts that column up by one row.
// After the last pixel of a frame the block runs FMAP_SIZE+3 flush cycles with
// conv_ena high and a zero tap, then pulses conv_clear/frame_done for one cycle.
//
// Optional build macro:
//   TAPGEN_ROW_MASK_EN - slots whose source row lies above the top of the frame
//                        read as zero instead of stale buffer contents.
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   pix_in     - raster pixel, row-major, row 0 first
//   pix_valid  - pix_in valid
//   pix_ready  - pixel accepted when pix_valid & pix_ready (combinational from state)
//   tap        - column vector, slot i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH],
//                slot KERNEL_SIZE-1 is the newest pixel (registered)
//   conv_ena   - engine enable aligned with tap (registered)
//   conv_clear - one-cycle engine clear pulse between frames (registered)
//   conv_done  - engine done flag, expected on the final flush cycle
//   frame_done - one-cycle pulse, frame fully processed (registered)
//   sync_err   - sticky: conv_done was low on the final flush cycle
module fmap_tap_gen #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FMAP_SIZE   = 32,
  parameter int unsigned KERNEL_SIZE = 5    // must be >= 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             pix_in,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0] tap,
  output logic                              conv_ena,
  output logic                              conv_clear,
  input  logic                              conv_done,
  output logic                              frame_done,
  output logic                              sync_err
);

  localparam int unsigned CNT_W   = (FMAP_SIZE > 1) ? $clog2(FMAP_SIZE) : 1;
  localparam int unsigned FLUSH_W = $clog2(FMAP_SIZE + 3);
  localparam int unsigned TAP_W   = DATA_WIDTH * KERNEL_SIZE;
  localparam int          NBUF    = KERNEL_SIZE - 1;

  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(FMAP_SIZE - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FMAP_SIZE + 2);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush,
    StClear
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   col_q, row_q;
  logic [FLUSH_W-1:0] flush_cnt_q;

  logic [TAP_W-1:0] tap_q, tap_d, tap_new;
  logic             ena_q, ena_d;
  logic             clear_q, clear_d;
  logic             done_pulse_q;
  logic             sync_err_q;

  logic stream_ph;   // states in which pixels are accepted
  logic accept;
  logic col_last, row_last, last_pix;
  logic flush_last;
  logic sync_fail;

  // Line buffer: line_buf[k] holds the row that feeds tap slot k.
  logic [DATA_WIDTH-1:0] line_buf [NBUF][FMAP_SIZE];

  // Decoded from the state register only, so accept has no path back into pix_ready.
  assign stream_ph  = (state_q == StIdle) || (state_q == StStream);
  assign accept     = pix_valid & stream_ph;
  assign col_last   = (col_q == LAST_IDX);
  assign row_last   = (row_q == LAST_IDX);
  assign last_pix   = col_last & row_last;
  assign flush_last = (flush_cnt_q == FLUSH_LAST);

  // conv_done is sampled on the final flush cycle; the engine must be done by then.
  assign sync_fail  = (state_q == StFlush) && flush_last && !conv_done;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = last_pix ? StFlush : StStream;
        end
      end
      StStream: begin
        if (accept && last_pix) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (flush_last) begin
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs (pix_ready directly, registered outputs via their next values)
  //--------------------------------------------------------------------------
  always_comb begin
    pix_ready = 1'b0;
    ena_d     = 1'b0;
    clear_d   = 1'b0;
    tap_d     = tap_q;   // stalls hold the last column
    unique case (state_q)
      StIdle, StStream: begin
        pix_ready = 1'b1;
        if (accept) begin
          ena_d = 1'b1;
          tap_d = tap_new;
        end
      end
      StFlush: begin
        ena_d = 1'b1;
        tap_d = '0;
      end
      StClear: begin
        clear_d = 1'b1;
      end
      default: begin
        pix_ready = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Column counter, row counter and flush counter
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (state_q == StFlush) begin
        flush_cnt_q <= flush_last ? '0 : flush_cnt_q + 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Row-valid flags and tap assembly
  //--------------------------------------------------------------------------
`ifdef TAPGEN_ROW_MASK_EN
  logic [NBUF-1:0] rv_q;

  // At each row end the newest buffered row becomes valid and older ones shift
  // toward slot 0, so in row r exactly slots k >= K-1-r are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
    end else if (state_q == StClear) begin
      rv_q <= '0;
    end else if (accept && col_last) begin
      rv_q <= NBUF'({1'b1, rv_q} >> 1);
    end
  end

  always_comb begin
    tap_new = '0;
    for (int k = 0; k < NBUF; k++) begin
      tap_new[k*DATA_WIDTH +: DATA_WIDTH] = rv_q[k] ? line_buf[k][col_q] : '0;
    end
    tap_new[NBUF*DATA_WIDTH +: DATA_WIDTH] = pix_in;
  end
`else
  always_comb begin
    tap_new = '0;
    for (int k = 0; k < NBUF; k++) begin
      tap_new[k*DATA_WIDTH +: DATA_WIDTH] = line_buf[k][col_q];
    end
    tap_new[NBUF*DATA_WIDTH +: DATA_WIDTH] = pix_in;
  end
`endif

  //--------------------------------------------------------------------------
  // Line buffer: shift the current column up one row, newest pixel at the top.
  // Contents are not reset; stale data is either masked or don't-care.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NBUF - 1; k++) begin
        line_buf[k][col_q] <= line_buf[k+1][col_q];
      end
      line_buf[NBUF-1][col_q] <= pix_in;
    end
  end

  //--------------------------------------------------------------------------
  // Registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q        <= '0;
      ena_q        <= 1'b0;
      clear_q      <= 1'b0;
      done_pulse_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      tap_q        <= tap_d;
      ena_q        <= ena_d;
      clear_q      <= clear_d;
      done_pulse_q <= clear_d;
      sync_err_q   <= sync_err_q | sync_fail;
    end
  end

  assign tap        = tap_q;
  assign conv_ena   = ena_q;
  assign conv_clear = clear_q;
  assign frame_done = done_pulse_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_fmap_tap_gen.sv
// Self-checking bench for fmap_tap_gen (FMAP_SIZE=8, KERNEL_SIZE=3, DATA_WIDTH=16).
// A frame-level reference model predicts every registered output each cycle;
// a table of known column vectors and per-frame counts cover the fixed corner cases.
module tb_fmap_tap_gen;

  localparam int DW = 16;
  localparam int F  = 8;
  localparam int K  = 3;
  localparam int TW = DW * K;
  localparam int ENA_PER_FRAME = F * (F + 1) + 3;

`ifdef TAPGEN_ROW_MASK_EN
  localparam bit MASKED    = 1'b1;
  localparam int FIRST_ROW = 0;
`else
  localparam bit MASKED    = 1'b0;
  localparam int FIRST_ROW = K - 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [TW-1:0] tap;
  logic          conv_ena;
  logic          conv_clear;
  logic          conv_done = 1'b0;
  logic          frame_done;
  logic          sync_err;

  always #5 clk = ~clk;

  fmap_tap_gen #(
    .DATA_WIDTH (DW),
    .FMAP_SIZE  (F),
    .KERNEL_SIZE(K)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .tap       (tap),
    .conv_ena  (conv_ena),
    .conv_clear(conv_clear),
    .conv_done (conv_done),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Known column vectors for the pattern frame pixel = row*F + col.
  typedef struct {
    int            r;
    int            c;
    logic [TW-1:0] exp;   // {slot2, slot1, slot0}
  } vec_t;
  vec_t tbl[$];

  // Reference model state
  logic [DW-1:0] cur  [F][F];
  logic [DW-1:0] prev [F][F];
  bit            prev_valid;
  int            pos;        // pixels accepted in the current frame
  int            gap;        // 0 while streaming, else cycle index after the last pixel
  logic [TW-1:0] m_tap, m_known;
  logic          m_ena, m_clear, m_sync;

  // Captured DUT taps per pixel and per-frame measurements
  logic [TW-1:0] cap  [F][F];
  logic [TW-1:0] cap_a[F][F];
  int            ena_cnt, low_cnt, frame_obs, clear_at;
  bit            seen_ena;

  task automatic model_reset();
    pos        = 0;
    gap        = 0;
    prev_valid = 1'b0;
    m_tap      = '0;
    m_known    = '1;
    m_ena      = 1'b0;
    m_clear    = 1'b0;
    m_sync     = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict the post-edge outputs, then compare.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic dn, output bit acc);
    int r, c;
    pix_valid = v;
    pix_in    = d;
    conv_done = dn;
    r = pos / F;
    c = pos % F;
    acc = v && (gap == 0);
    m_clear = (gap == F + 4);
    if (gap == F + 3 && !dn) m_sync = 1'b1;
    if (acc) begin
      cur[r][c] = d;
      m_ena = 1'b1;
      for (int k = 0; k < K; k++) begin
        int src;
        src = r - (K - 1) + k;
        m_known[k*DW +: DW] = '1;
        if (src >= 0) begin
          m_tap[k*DW +: DW] = cur[src][c];
        end else if (MASKED) begin
          m_tap[k*DW +: DW] = '0;
        end else if (prev_valid) begin
          m_tap[k*DW +: DW] = prev[F + src][c];
        end else begin
          m_tap[k*DW +: DW]   = '0;
          m_known[k*DW +: DW] = '0;
        end
      end
      pos++;
      if (pos == F * F) begin
        pos        = 0;
        gap        = 1;
        prev       = cur;
        prev_valid = 1'b1;
      end
    end else if (gap >= 1 && gap <= F + 3) begin
      m_ena   = 1'b1;
      m_tap   = '0;
      m_known = '1;
      gap++;
    end else begin
      m_ena = 1'b0;
      if (gap == F + 4) gap = 0;
    end

    @(posedge clk);
    #1;
    check("pix_ready", pix_ready, (gap == 0));
    check("conv_ena", conv_ena, m_ena);
    check("conv_clear", conv_clear, m_clear);
    check("frame_done", frame_done, m_clear);
    check("sync_err", sync_err, m_sync);
    check("tap", tap & m_known, m_tap & m_known);

    if (acc) cap[r][c] = tap;
    if (conv_ena) ena_cnt++;
    if (!pix_ready) low_cnt++;
    if (conv_ena) seen_ena = 1'b1;
    if (seen_ena) frame_obs++;
    if (conv_clear && clear_at == 0) clear_at = frame_obs;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    conv_done = 1'b0;
    rst_n     = 1'b0;
    #3;
    check("reset pix_ready", pix_ready, 1'b1);
    check("reset tap", tap, '0);
    check("reset conv_ena", conv_ena, 1'b0);
    check("reset conv_clear", conv_clear, 1'b0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset sync_err", sync_err, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // mode 0: pixel = raster index (row*F+col); mode 1: random data.
  // done_at: gap cycle on which conv_done pulses (F+3 is the last flush cycle).
  // abort_after >= 0: return right after accepting that raster index.
  task automatic run_frame(input int mode, input int stall_pct, input int done_at,
                           input int abort_after);
    bit acc;
    int i;
    ena_cnt   = 0;
    low_cnt   = 0;
    frame_obs = 0;
    clear_at  = 0;
    seen_ena  = 1'b0;
    i = 0;
    while (i < F * F) begin
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        cycle(1'b0, DW'($urandom), 1'b0, acc);
      end else begin
        cycle(1'b1, (mode == 0) ? DW'(i) : DW'($urandom), 1'b0, acc);
        if (acc) begin
          if (abort_after >= 0 && i == abort_after) return;
          i++;
        end
      end
    end
    // pix_valid stays high through flush/clear; it must be ignored.
    for (int j = 1; j <= F + 4; j++) begin
      cycle(1'b1, DW'($urandom), (j == done_at), acc);
    end
    check("ena_cycles_per_frame", ena_cnt, ENA_PER_FRAME);
    check("pix_ready_low_cycles", low_cnt, F + 4);
    if (stall_pct == 0) check("clear_cycle_index", clear_at, ENA_PER_FRAME + 1);
  endtask

  task automatic check_table(input string name);
    foreach (tbl[n]) begin
      check(name, cap[tbl[n].r][tbl[n].c], tbl[n].exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    tbl.push_back('{r: 2, c: 5, exp: {16'd21, 16'd13, 16'd5}});
    tbl.push_back('{r: 2, c: 0, exp: {16'd16, 16'd8, 16'd0}});
    tbl.push_back('{r: 7, c: 7, exp: {16'd63, 16'd55, 16'd47}});
    tbl.push_back('{r: 4, c: 1, exp: {16'd33, 16'd25, 16'd17}});
`ifdef TAPGEN_ROW_MASK_EN
    tbl.push_back('{r: 0, c: 3, exp: {16'd3, 16'd0, 16'd0}});
    tbl.push_back('{r: 1, c: 3, exp: {16'd11, 16'd3, 16'd0}});
    tbl.push_back('{r: 0, c: 0, exp: {16'd0, 16'd0, 16'd0}});
`endif

    #1;
    do_reset();

    // A: continuous pattern frame, conv_done on the last flush cycle.
    run_frame(0, 0, F + 3, -1);
    check_table("table frame A");
    check("sync_err after good done", sync_err, 1'b0);
    cap_a = cap;

    // B: same data with ~30% stalls, back-to-back; taps must match frame A.
    run_frame(0, 30, F + 3, -1);
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        if (r >= FIRST_ROW) check("stall vs continuous tap", cap[r][c], cap_a[r][c]);
      end
    end

    // C: random data, conv_done one cycle early -> sync_err.
    run_frame(1, 0, F + 2, -1);
    check("sync_err after early done", sync_err, 1'b1);

    // D: pattern frame right after random data; sync_err stays set.
    run_frame(0, 0, F + 3, -1);
    check_table("table frame D");
    check("sync_err sticky", sync_err, 1'b1);

    // E: abort at pixel (4,2) with reset, then a full frame.
    run_frame(0, 0, F + 3, 4 * F + 2);
    do_reset();
    run_frame(0, 0, F + 3, -1);
    check("first tap slot2 after reset", cap[0][0][TW-1 -: DW], '0);
    check_table("table frame after reset");

    repeat (3) cycle(1'b0, '0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
